// File: rtl/sprite_tile_renderer.sv
// Per-frame sprite renderer: optional background repaint, erase of moved/disabled
// sprites, then priority-ordered redraw with colour-key transparency onto a VGA write port.
module sprite_tile_renderer #(
  parameter int                 N_SPR     = 4,
  parameter int                 TILE      = 5,
  parameter int                 GX_W      = 5,
  parameter int                 GY_W      = 4,
  parameter int                 SCR_W     = 160,
  parameter int                 SCR_H     = 120,
  parameter int                 COLOR_W   = 12,
  parameter int                 ROM_LAT   = 2,
  parameter logic [COLOR_W-1:0] KEY_COLOR = 12'hF0F,
  parameter int                 SA_W      = $clog2(N_SPR * TILE * TILE)
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    start,
  input  logic                    full_redraw,
  input  logic [N_SPR-1:0]        spr_en,
  input  logic [N_SPR*GX_W-1:0]   spr_gx,
  input  logic [N_SPR*GY_W-1:0]   spr_gy,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              bg_x,
  output logic [6:0]              bg_y,
  input  logic [COLOR_W-1:0]      bg_color,
  output logic [SA_W-1:0]         spr_addr,
  input  logic [COLOR_W-1:0]      spr_color,
  output logic [7:0]              vga_x,
  output logic [6:0]              vga_y,
  output logic [COLOR_W-1:0]      vga_color,
  output logic                    vga_we
);

  localparam int IW  = (N_SPR > 1) ? $clog2(N_SPR) : 1;
  localparam int IW1 = IW + 1;
  localparam int DW  = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int LW  = $clog2(ROM_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_BG, S_ERASE, S_DRAW, S_FLUSH, S_DONE} state_t;

  typedef struct packed {
    logic       v;
    logic       ok;
    logic       is_spr;
    logic [7:0] x;
    logic [6:0] y;
  } slot_t;

  state_t                state;
  logic [IW-1:0]         cur_i;
  logic [DW-1:0]         dx, dy;
  logic [7:0]            bx;
  logic [6:0]            by;
  logic [LW-1:0]         fl_cnt;
  logic                  first_frame;
  logic [N_SPR-1:0]      drawn;
  logic [GX_W-1:0]       last_gx [N_SPR];
  logic [GY_W-1:0]       last_gy [N_SPR];
  logic [N_SPR-1:0]      en_q;
  logic [N_SPR*GX_W-1:0] gx_q;
  logic [N_SPR*GY_W-1:0] gy_q;
  slot_t                 pipe [ROM_LAT];

  logic [N_SPR-1:0]      en_eff, erase_q;
  logic [N_SPR*GX_W-1:0] gx_eff;
  logic [N_SPR*GY_W-1:0] gy_eff;
  logic [IW:0]           erase_first, erase_next, draw_first, draw_next, cur_next;
  state_t                ent_d_state, ent_e_state;
  logic [IW-1:0]         ent_d_idx, ent_e_idx;
  logic [GX_W-1:0]       sel_gx;
  logic [GY_W-1:0]       sel_gy;
  logic [8:0]            px;
  logic [7:0]            py;
  slot_t                 slot;

  // Lowest set index >= from; MSB of the result flags "none found".
  function automatic logic [IW:0] find_from(input logic [N_SPR-1:0] m, input logic [IW:0] from);
    logic [IW:0] r;
    r = {1'b1, {IW{1'b0}}};
    for (int j = N_SPR - 1; j >= 0; j--)
      if (m[j] && (IW1'(j) >= from)) r = {1'b0, IW'(j)};
    return r;
  endfunction

  // In IDLE the live inputs stand in for the snapshot so the start edge can pick the first slot.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    en_eff  = (state == S_IDLE) ? spr_en : en_q;
    gx_eff  = (state == S_IDLE) ? spr_gx : gx_q;
    gy_eff  = (state == S_IDLE) ? spr_gy : gy_q;
    erase_q = '0;
    for (int i = 0; i < N_SPR; i++)
      erase_q[i] = drawn[i] && (!en_eff[i] ||
                                gx_eff[i*GX_W +: GX_W] != last_gx[i] ||
                                gy_eff[i*GY_W +: GY_W] != last_gy[i]);
    cur_next    = IW1'(cur_i) + IW1'(1);
    erase_first = find_from(erase_q, '0);
    erase_next  = find_from(erase_q, cur_next);
    draw_first  = find_from(en_eff, '0);
    draw_next   = find_from(en_eff, cur_next);
  end

  always_comb begin
    ent_d_state = S_FLUSH;
    ent_d_idx   = '0;
    if (!draw_first[IW]) begin
      ent_d_state = S_DRAW;
      ent_d_idx   = draw_first[IW-1:0];
    end
    ent_e_state = ent_d_state;
    ent_e_idx   = ent_d_idx;
    if (!erase_first[IW]) begin
      ent_e_state = S_ERASE;
      ent_e_idx   = erase_first[IW-1:0];
    end
  end

  always_comb begin
    sel_gx      = (state == S_ERASE) ? last_gx[cur_i] : gx_q[cur_i*GX_W +: GX_W];
    sel_gy      = (state == S_ERASE) ? last_gy[cur_i] : gy_q[cur_i*GY_W +: GY_W];
    px          = 9'(sel_gx) * 9'(TILE) + 9'(dx);
    py          = 8'(sel_gy) * 8'(TILE) + 8'(dy);
    slot.v      = (state == S_BG) || (state == S_ERASE) || (state == S_DRAW);
    slot.is_spr = (state == S_DRAW);
    slot.x      = px[7:0];
    slot.y      = py[6:0];
    slot.ok     = (px < 9'(SCR_W)) && (py < 8'(SCR_H));
    if (state == S_BG) begin
      slot.x  = bx;
      slot.y  = by;
      slot.ok = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      cur_i       <= '0;
      dx          <= '0;
      dy          <= '0;
      bx          <= '0;
      by          <= '0;
      fl_cnt      <= '0;
      first_frame <= 1'b1;
      drawn       <= '0;
      en_q        <= '0;
      gx_q        <= '0;
      gy_q        <= '0;
      bg_x        <= '0;
      bg_y        <= '0;
      spr_addr    <= '0;
      // NOTE: last-position table is small and its reset value is architectural, so it is reset.
      for (int i = 0; i < N_SPR; i++) begin
        last_gx[i] <= '0;
        last_gy[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (state == S_BG || state == S_ERASE) begin
        bg_x <= slot.x;
        bg_y <= slot.y;
      end
      if (state == S_DRAW)
        spr_addr <= SA_W'(cur_i) * SA_W'(TILE * TILE) + SA_W'(dy) * SA_W'(TILE) + SA_W'(dx);

      case (state)
        S_IDLE: if (start) begin
          busy   <= 1'b1;
          en_q   <= spr_en;
          gx_q   <= spr_gx;
          gy_q   <= spr_gy;
          bx     <= '0;
          by     <= '0;
          dx     <= '0;
          dy     <= '0;
          fl_cnt <= '0;
          if (full_redraw || first_frame) begin
            state <= S_BG;
          end else begin
            state <= ent_e_state;
            cur_i <= ent_e_idx;
          end
        end
        S_BG: begin
          if (bx == 8'(SCR_W - 1)) begin
            bx <= '0;
            if (by == 7'(SCR_H - 1)) begin
              by          <= '0;
              first_frame <= 1'b0;
              state       <= ent_d_state;
              cur_i       <= ent_d_idx;
            end else begin
              by <= by + 7'd1;
            end
          end else begin
            bx <= bx + 8'd1;
          end
        end
        S_ERASE, S_DRAW: begin
          if (dx == DW'(TILE - 1)) begin
            dx <= '0;
            if (dy == DW'(TILE - 1)) begin
              dy <= '0;
              if (state == S_DRAW) begin
                last_gx[cur_i] <= gx_q[cur_i*GX_W +: GX_W];
                last_gy[cur_i] <= gy_q[cur_i*GY_W +: GY_W];
                drawn[cur_i]   <= 1'b1;
                if (!draw_next[IW]) cur_i <= draw_next[IW-1:0];
                else                state <= S_FLUSH;
              end else if (!erase_next[IW]) begin
                cur_i <= erase_next[IW-1:0];
              end else begin
                state <= ent_d_state;
                cur_i <= ent_d_idx;
              end
            end else begin
              dy <= dy + DW'(1);
            end
          end else begin
            dx <= dx + DW'(1);
          end
        end
        S_FLUSH: begin
          drawn <= drawn & en_q;
          if (fl_cnt == LW'(ROM_LAT - 1)) state  <= S_DONE;
          else                            fl_cnt <= fl_cnt + LW'(1);
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Slot attributes ride alongside the ROM latency so each write meets its own data.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < ROM_LAT; s++) pipe[s] <= '0;
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= '0;
      vga_we    <= 1'b0;
    end else begin
      pipe[0] <= slot;
      for (int s = 1; s < ROM_LAT; s++) pipe[s] <= pipe[s-1];
      vga_we <= 1'b0;
      if (pipe[ROM_LAT-1].v) begin
        vga_x     <= pipe[ROM_LAT-1].x;
        vga_y     <= pipe[ROM_LAT-1].y;
        vga_color <= pipe[ROM_LAT-1].is_spr ? spr_color : bg_color;
        vga_we    <= pipe[ROM_LAT-1].ok &&
                     !(pipe[ROM_LAT-1].is_spr && spr_color == KEY_COLOR);
      end
    end
  end

endmodule
